song_reader: RTL and testbench

- Sequencer that walks one song stored in the song ROM and decodes each 16-bit entry.
- Note entries are dispatched to note-player voices, round-robin.
- Advance entries stall the walk for a given number of beats.
- Sits between the song ROM and the note players; paced by the beat generator and controlled by the top-level play/song-select logic.

---
 rtl/song_pkg.sv | 31 +++
 rtl/beat_counter.sv | 35 +++
 rtl/song_reader.sv | 149 ++++++++++++++
 tb/tb_song_reader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: entry field layout, FSM states, widths.
// Entry: bit15=0 note {note[14:9], dur[8:3]}, bit15=1 advance {wait[14:9]}.
package song_pkg;

    localparam int ENTRY_W        = 16;
    localparam int ENTRY_TYPE_BIT = 15;
    localparam int NOTE_MSB       = 14;
    localparam int NOTE_LSB       = 9;
    localparam int DUR_MSB        = 8;
    localparam int DUR_LSB        = 3;
    localparam int ADV_MSB        = 14;
    localparam int ADV_LSB        = 9;

    localparam int NOTE_W     = 6;
    localparam int DUR_W      = 6;
    localparam int WAIT_W     = ADV_MSB - ADV_LSB + 1;
    localparam int SONG_SEL_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        WAIT_BEATS,
        DONE
    } state_e;

    function automatic logic is_advance(input logic [ENTRY_W-1:0] entry);
        return entry[ENTRY_TYPE_BIT];
    endfunction

endpackage

// File: rtl/beat_counter.sv
// Beat-down counter for advance entries: load a wait, decrement on each beat.
// expire_o is high while the count is 1, i.e. the next beat ends the wait.
module beat_counter
    import song_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [WAIT_W-1:0] load_val_i,
    input  logic              beat_i,
    output logic              expire_o
);

    logic [WAIT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (beat_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == WAIT_W'(1));

endmodule

// File: rtl/song_reader.sv
// Walks one song in the song ROM, dispatching notes round-robin and stalling on advance entries.
// Optional SONG_READER_LOOP_EN: restart at offset 0 of the latched song instead of stopping in DONE.
module song_reader
    import song_pkg::*;
#(
    parameter int NUM_VOICES    = 3,
    parameter int SONG_LEN_LOG2 = 5
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                play,
    input  logic [SONG_SEL_W-1:0]               song,
    input  logic                                beat,
    output logic [SONG_SEL_W+SONG_LEN_LOG2-1:0] rom_addr,
    input  logic [ENTRY_W-1:0]                  rom_dout,
    output logic [NUM_VOICES-1:0]               note_load,
    output logic [NOTE_W-1:0]                   note,
    output logic [DUR_W-1:0]                    duration,
    output logic                                song_done,
    output logic                                busy
);

    localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [SONG_LEN_LOG2-1:0] LAST_OFS = '1;

    state_e                   state_q, state_d;
    logic [SONG_SEL_W-1:0]    song_q, song_d;
    logic [SONG_LEN_LOG2-1:0] offset_q, offset_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [NOTE_W-1:0]        note_q, note_d;
    logic [DUR_W-1:0]         dur_q, dur_d;
    logic [NUM_VOICES-1:0]    load_q, load_d;
    logic                     done_q, done_d;

    logic                     cnt_load, cnt_beat, cnt_expire, advance;
    logic [WAIT_W-1:0]        adv_wait;
    logic                     unused_rom_bits;

    assign adv_wait        = rom_dout[ADV_MSB:ADV_LSB];
    assign unused_rom_bits = ^rom_dout[DUR_LSB-1:0];

    beat_counter u_beat_counter (
        .clk       (clk),
        .reset     (reset),
        .load_i    (cnt_load),
        .load_val_i(adv_wait),
        .beat_i    (cnt_beat),
        .expire_o  (cnt_expire)
    );

    always_comb begin
        state_d  = state_q;
        song_d   = song_q;
        offset_d = offset_q;
        ptr_d    = ptr_q;
        note_d   = note_q;
        dur_d    = dur_q;
        load_d   = '0;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_beat = 1'b0;
        advance  = 1'b0;

        // play low outside IDLE/DONE holds everything where it is
        case (state_q)
            IDLE: begin
                if (play) begin
                    song_d   = song;
                    offset_d = '0;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                if (play) state_d = DECODE;
            end
            DECODE: begin
                if (play) begin
                    if (!is_advance(rom_dout)) begin
                        note_d  = rom_dout[NOTE_MSB:NOTE_LSB];
                        dur_d   = rom_dout[DUR_MSB:DUR_LSB];
                        load_d  = NUM_VOICES'(1) << ptr_q;
                        ptr_d   = (ptr_q == PTR_W'(NUM_VOICES - 1)) ? '0 : ptr_q + 1'b1;
                        advance = 1'b1;
                    end else if (adv_wait != '0) begin
                        cnt_load = 1'b1;
                        state_d  = WAIT_BEATS;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            WAIT_BEATS: begin
                if (play && beat) begin
                    cnt_beat = 1'b1;
                    advance  = cnt_expire;
                end
            end
            DONE: begin
                if (!play) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (offset_q == LAST_OFS) begin
                done_d = 1'b1;
`ifdef SONG_READER_LOOP_EN
                offset_d = '0;
                state_d  = FETCH;
`else
                state_d  = DONE;
`endif
            end else begin
                offset_d = offset_q + 1'b1;
                state_d  = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            song_q   <= '0;
            offset_q <= '0;
            ptr_q    <= '0;
            note_q   <= '0;
            dur_q    <= '0;
            load_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            song_q   <= song_d;
            offset_q <= offset_d;
            ptr_q    <= ptr_d;
            note_q   <= note_d;
            dur_q    <= dur_d;
            load_q   <= load_d;
            done_q   <= done_d;
        end
    end

    assign rom_addr  = {song_q, offset_q};
    assign note_load = load_q;
    assign note      = note_q;
    assign duration  = dur_q;
    assign song_done = done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: registered ROM model, periodic beat source, dispatch scoreboard.
module tb_song_reader;

    logic        clk = 1'b0;
    logic        reset, play, beat;
    logic [1:0]  song;
    logic [6:0]  rom_addr;
    logic [15:0] rom_dout;
    logic [2:0]  note_load;
    logic [5:0]  note, duration;
    logic        song_done, busy;

    song_reader #(.NUM_VOICES(3), .SONG_LEN_LOG2(5)) dut (
        .clk(clk), .reset(reset), .play(play), .song(song), .beat(beat),
        .rom_addr(rom_addr), .rom_dout(rom_dout), .note_load(note_load),
        .note(note), .duration(duration), .song_done(song_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] load;
        logic [5:0] note;
        logic [5:0] dur;
        int         stamp;
    } disp_t;

    logic [15:0] rom [128];
    disp_t exp_q[$], obs_q[$];
    int    done_q[$], beat_edges[$];
    int    cyc = 0;
    int    checks = 0, errors = 0;
    bit    beat_en = 1'b0;

    function automatic logic [15:0] n_ent(input int n, input int d);
        return {1'b0, 6'(n), 6'(d), 3'b101};
    endfunction

    function automatic logic [15:0] a_ent(input int w);
        return {1'b1, 6'(w), 9'h0a5};
    endfunction

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = a_ent(0);
        rom[0] = n_ent(40, 48); rom[1] = a_ent(12);
        rom[2] = n_ent(44, 36); rom[3] = a_ent(12);
        rom[4] = n_ent(47, 24); rom[5] = a_ent(24);
        for (int k = 0; k < 9; k++) begin
            rom[32 + 2*k] = n_ent(40 + k, 12);
            if (k < 8) rom[33 + 2*k] = a_ent(12);
        end
        rom[64] = n_ent(52, 48);
        rom[96] = n_ent(40, 48);
    end

    always @(posedge clk) rom_dout <= rom[rom_addr];
    always @(posedge clk) cyc <= cyc + 1;
    // edge index of every beat the DUT could count (play high)
    always @(posedge clk) if (beat && play) beat_edges.push_back(cyc + 1);

    always @(negedge clk) begin
        if (note_load != 3'b000) obs_q.push_back('{note_load, note, duration, cyc});
        if (song_done) done_q.push_back(cyc);
    end

    initial begin
        int ph = 0;
        beat = 1'b0;
        forever begin
            @(negedge clk);
            beat = beat_en && (ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; play = 1'b0; beat_en = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
        obs_q.delete(); done_q.delete(); exp_q.delete(); beat_edges.delete();
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (done_q.size() == 0 && n < budget) begin step(1); n++; end
        ok = (done_q.size() != 0);
    endtask

    task automatic wait_obs(input int cnt, input int budget, output bit ok);
        int n = 0;
        while (obs_q.size() < cnt && n < budget) begin step(1); n++; end
        ok = (obs_q.size() >= cnt);
    endtask

    task automatic test_reset();
        reset = 1'b1; play = 1'b1; song = 2'd2; beat_en = 1'b0;
        step(3);
        checks++; if (rom_addr !== 7'd0)  begin errors++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
        checks++; if (note_load !== 3'd0) begin errors++; $display("FAIL reset_note_load got %b want 000", note_load); end
        checks++; if (note !== 6'd0)      begin errors++; $display("FAIL reset_note got %0d want 0", note); end
        checks++; if (duration !== 6'd0)  begin errors++; $display("FAIL reset_duration got %0d want 0", duration); end
        checks++; if (song_done !== 1'b0) begin errors++; $display("FAIL reset_song_done got %b want 0", song_done); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        song = 2'd0;
        do_reset();
        step(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_song0_and_select();
        int t0; bit ok; disp_t e, o;
        do_reset();
        beat_en = 1'b1; song = 2'd0; play = 1'b1; t0 = cyc;
        exp_q.push_back('{3'b001, 6'd40, 6'd48, t0 + 3});
        exp_q.push_back('{3'b010, 6'd44, 6'd36, -1});
        exp_q.push_back('{3'b100, 6'd47, 6'd24, -1});
        step(1);
        checks++; if (rom_addr !== 7'd0) begin errors++; $display("FAIL s0_rom_addr got %0d want 0", rom_addr); end
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL s0_busy got %b want 1", busy); end
        step(5);
        song = 2'd3;
        wait_done(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL s0_done_timeout got none want song_done"); end
        checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL s0_count got %0d want 3", obs_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.load !== e.load) begin errors++; $display("FAIL s0_voice got %b want %b", o.load, e.load); end
            checks++; if (o.note !== e.note) begin errors++; $display("FAIL s0_note got %0d want %0d", o.note, e.note); end
            checks++; if (o.dur !== e.dur)   begin errors++; $display("FAIL s0_dur got %0d want %0d", o.dur, e.dur); end
            if (e.stamp >= 0) begin
                checks++; if (o.stamp != e.stamp) begin errors++; $display("FAIL s0_latency got %0d want %0d", o.stamp - t0, e.stamp - t0); end
            end
        end
`ifndef SONG_READER_LOOP_EN
        step(10);
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL s0_done_count got %0d want 1", done_q.size()); end
        checks++; if (song_done !== 1'b0) begin errors++; $display("FAIL s0_done_pulse got %b want 0", song_done); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL s0_done_busy got %b want 1", busy); end
        play = 1'b0;
        step(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL s0_to_idle_busy got %b want 0", busy); end
        obs_q.delete(); done_q.delete(); exp_q.delete();
`else
        do_reset();
`endif
        song = 2'd3; play = 1'b1; t0 = cyc;
        exp_q.push_back('{3'b001, 6'd40, 6'd48, t0 + 3});
        step(1);
        checks++; if (rom_addr !== 7'd96) begin errors++; $display("FAIL s3_rom_addr got %0d want 96", rom_addr); end
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL s3_done_timeout got none want song_done"); end
        else begin
            checks++; if (done_q[0] != t0 + 65) begin errors++; $display("FAIL s3_done_time got %0d want 65", done_q[0] - t0); end
        end
        checks++; if (obs_q.size() == 0) begin errors++; $display("FAIL s3_dispatch got none want 1"); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.load !== e.load)   begin errors++; $display("FAIL s3_voice got %b want %b", o.load, e.load); end
            checks++; if (o.note !== e.note)   begin errors++; $display("FAIL s3_note got %0d want %0d", o.note, e.note); end
            checks++; if (o.dur !== e.dur)     begin errors++; $display("FAIL s3_dur got %0d want %0d", o.dur, e.dur); end
            checks++; if (o.stamp != e.stamp)  begin errors++; $display("FAIL s3_latency got %0d want %0d", o.stamp - t0, e.stamp - t0); end
        end
    endtask

    task automatic test_song1_rotation();
        bit ok; disp_t e, o; int prev;
        do_reset();
        beat_en = 1'b1; song = 2'd1; play = 1'b1;
        for (int k = 0; k < 9; k++) exp_q.push_back('{3'(1 << (k % 3)), 6'(40 + k), 6'd12, -1});
        wait_done(4000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL s1_done_timeout got none want song_done"); end
        checks++; if (obs_q.size() != 9) begin errors++; $display("FAIL s1_count got %0d want 9", obs_q.size()); end
        prev = -1;
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.load !== e.load) begin errors++; $display("FAIL s1_voice got %b want %b", o.load, e.load); end
            checks++; if (o.note !== e.note) begin errors++; $display("FAIL s1_note got %0d want %0d", o.note, e.note); end
            checks++; if (o.dur !== e.dur)   begin errors++; $display("FAIL s1_dur got %0d want %0d", o.dur, e.dur); end
            if (prev >= 0) begin
                checks++;
                if (o.stamp - prev < 49 || o.stamp - prev > 52) begin
                    errors++; $display("FAIL s1_spacing got %0d want 49..52", o.stamp - prev);
                end
            end
            prev = o.stamp;
        end
    endtask

    task automatic test_song2_no_wait();
        int t0; bit ok; disp_t e, o;
        do_reset();
        beat_en = 1'b0; song = 2'd2; play = 1'b1; t0 = cyc;
        exp_q.push_back('{3'b001, 6'd52, 6'd48, t0 + 3});
`ifdef SONG_READER_LOOP_EN
        exp_q.push_back('{3'b010, 6'd52, 6'd48, t0 + 67});
`endif
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL s2_done_timeout got none want song_done"); end
        else begin
            checks++; if (done_q[0] != t0 + 65) begin errors++; $display("FAIL s2_done_time got %0d want 65", done_q[0] - t0); end
        end
        step(5);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL s2_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o.load !== e.load)  begin errors++; $display("FAIL s2_voice got %b want %b", o.load, e.load); end
            checks++; if (o.note !== e.note)  begin errors++; $display("FAIL s2_note got %0d want %0d", o.note, e.note); end
            checks++; if (o.dur !== e.dur)    begin errors++; $display("FAIL s2_dur got %0d want %0d", o.dur, e.dur); end
            checks++; if (o.stamp != e.stamp) begin errors++; $display("FAIL s2_time got %0d want %0d", o.stamp - t0, e.stamp - t0); end
        end
    endtask

    task automatic test_pause_in_wait();
        bit ok; int d1, a0, n, want;
        do_reset();
        beat_en = 1'b1; song = 2'd0; play = 1'b1;
        wait_obs(1, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pause_first_timeout got none want dispatch"); end
        d1 = ok ? obs_q[0].stamp : cyc;
        step(10);
        play = 1'b0; a0 = rom_addr;
        step(20);
        checks++; if (obs_q.size() != 1)    begin errors++; $display("FAIL pause_no_dispatch got %0d want 1", obs_q.size()); end
        checks++; if (rom_addr !== 7'(a0))  begin errors++; $display("FAIL pause_rom_addr got %0d want %0d", rom_addr, a0); end
        checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL pause_busy got %b want 1", busy); end
        play = 1'b1;
        wait_obs(2, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pause_resume_timeout got none want dispatch"); end
        else begin
            n = 0; want = -1;
            foreach (beat_edges[i]) begin
                if (beat_edges[i] > d1 + 2 && want < 0) begin
                    n++;
                    if (n == 12) want = beat_edges[i] + 2;
                end
            end
            checks++; if (obs_q[1].stamp != want) begin errors++; $display("FAIL pause_resume_time got %0d want %0d", obs_q[1].stamp, want); end
            checks++; if (obs_q[1].note !== 6'd44) begin errors++; $display("FAIL pause_note got %0d want 44", obs_q[1].note); end
            checks++; if (obs_q[1].load !== 3'b010) begin errors++; $display("FAIL pause_voice got %b want 010", obs_q[1].load); end
        end
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        do_reset();
        beat_en = 1'b1; song = 2'd0; play = 1'b1;
        wait_obs(1, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstw_first_timeout got none want dispatch"); end
        step(12);
        reset = 1'b1;
        step(1);
        checks++; if (rom_addr !== 7'd0)  begin errors++; $display("FAIL rstw_rom_addr got %0d want 0", rom_addr); end
        checks++; if (note_load !== 3'd0) begin errors++; $display("FAIL rstw_note_load got %b want 000", note_load); end
        checks++; if (note !== 6'd0)      begin errors++; $display("FAIL rstw_note got %0d want 0", note); end
        checks++; if (duration !== 6'd0)  begin errors++; $display("FAIL rstw_duration got %0d want 0", duration); end
        checks++; if (song_done !== 1'b0) begin errors++; $display("FAIL rstw_song_done got %b want 0", song_done); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rstw_busy got %b want 0", busy); end
        reset = 1'b0; play = 1'b0;
        step(2);
    endtask

    initial begin
        test_reset();
        test_song0_and_select();
        test_song1_rotation();
        test_song2_no_wait();
        test_pause_in_wait();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
